// File: rtl/config_jtag_pkg.sv
// Shared types and defaults for the serial configuration loader.
package config_jtag_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CHECK  = 2'd1,
    S_COMMIT = 2'd2
  } state_e;

  localparam logic [15:0]   SYNC_LOAD_DEF = 16'hFAB1;
  localparam logic [15:0]   SYNC_RST_DEF  = 16'hFAB0;
  localparam int unsigned   TIMEOUT_DEF   = 34;

  // Channel-address width; a single channel still needs one address bit.
  function automatic int unsigned addr_width(input int unsigned nch);
    return (nch <= 1) ? 1 : $clog2(nch);
  endfunction

endpackage

// File: rtl/cfg_sync_detect.sv
// TMS history register plus the commit / reset-request pattern comparators.
module cfg_sync_detect
  import config_jtag_pkg::*;
#(
  parameter int unsigned           TMS_W     = 16,
  parameter logic [TMS_W-1:0]      SYNC_LOAD = TMS_W'(SYNC_LOAD_DEF),
  parameter logic [TMS_W-1:0]      SYNC_RST  = TMS_W'(SYNC_RST_DEF)
) (
  input  logic clk,
  input  logic reset,
  input  logic tms_i,
  output logic load_match_c_o,
  output logic rst_match_c_o
);

  logic [TMS_W-1:0] tms_q, tms_d;

  always_comb begin
    tms_d = {tms_q[TMS_W-2:0], tms_i};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tms_q <= '0;
    end else begin
      tms_q <= tms_d;
    end
  end

  // Patterns are nonzero, so a freshly cleared history never matches.
  assign load_match_c_o = (tms_q == SYNC_LOAD);
  assign rst_match_c_o  = (tms_q == SYNC_RST);

endmodule

// File: rtl/config_jtag_mc.sv
// Serial multi-channel config loader: frames are shifted in on data_in and
// committed to a channel when the TMS line carries the load pattern.
module config_jtag_mc
  import config_jtag_pkg::*;
#(
  parameter int unsigned      DATA_W    = 32,
  parameter int unsigned      NCH       = 4,
  parameter int unsigned      TMS_W     = 16,
  parameter logic [TMS_W-1:0] SYNC_LOAD = TMS_W'(SYNC_LOAD_DEF),
  parameter logic [TMS_W-1:0] SYNC_RST  = TMS_W'(SYNC_RST_DEF),
  parameter int unsigned      PARITY_EN = 1,
  parameter int unsigned      TIMEOUT   = TIMEOUT_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tms,
  input  logic                  data_in,
  output logic                  reset_out,
  output logic [NCH-1:0]        strobe,
  output logic [NCH*DATA_W-1:0] data_out,
  output logic                  err
);

  localparam int unsigned ADDR_W  = addr_width(NCH);
  localparam int unsigned FRAME_W = ADDR_W + DATA_W + PARITY_EN;
  localparam int unsigned TO_W    = $clog2(TIMEOUT + 1);

  logic load_match, rst_match;

  cfg_sync_detect #(
    .TMS_W     (TMS_W),
    .SYNC_LOAD (SYNC_LOAD),
    .SYNC_RST  (SYNC_RST)
  ) u_sync (
    .clk            (clk),
    .reset          (reset),
    .tms_i          (tms),
    .load_match_c_o (load_match),
    .rst_match_c_o  (rst_match)
  );

  state_e                state_q, state_d;
  logic [FRAME_W-1:0]    frame_q, frame_d;
  logic [FRAME_W-1:0]    hold_q, hold_d;
  logic [NCH*DATA_W-1:0] data_q, data_d;
  logic [NCH-1:0]        strobe_q, strobe_d;
  logic                  err_q, err_d;
  logic                  reset_out_q, reset_out_d;
  logic [TO_W-1:0]       wd_q, wd_d;

  logic [ADDR_W-1:0]     hold_addr;
  logic [DATA_W-1:0]     hold_payload;
  logic                  addr_ok, parity_ok, frame_ok;

  // Held frame decode: address on top, payload, then optional parity bit.
  assign hold_addr    = hold_q[FRAME_W-1 -: ADDR_W];
  assign hold_payload = hold_q[PARITY_EN +: DATA_W];
  assign addr_ok      = (32'(hold_addr) < NCH);
  assign parity_ok    = (PARITY_EN == 0) || !(^hold_q);
  assign frame_ok     = addr_ok && parity_ok;

  always_comb begin
    state_d     = state_q;
    frame_d     = {frame_q[FRAME_W-2:0], data_in};
    hold_d      = hold_q;
    data_d      = data_q;
    strobe_d    = '0;
    err_d       = 1'b0;
    reset_out_d = 1'b0;
    wd_d        = wd_q;

    if (state_q == S_COMMIT) begin
      wd_d = TO_W'(TIMEOUT);
    end else if (wd_q != '0) begin
      wd_d = wd_q - TO_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (load_match) begin
          hold_d  = frame_q;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (frame_ok) begin
          state_d = S_COMMIT;
          for (int unsigned k = 0; k < NCH; k++) begin
            if (32'(hold_addr) == k) begin
              strobe_d[k]                   = 1'b1;
              data_d[k*DATA_W +: DATA_W]    = hold_payload;
            end
          end
        end else begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end
      end
      S_COMMIT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    // Reset request wins over everything: abort, disarm, and signal downstream.
    if (rst_match) begin
      state_d     = S_IDLE;
      wd_d        = '0;
      strobe_d    = '0;
      err_d       = 1'b0;
      data_d      = data_q;
      reset_out_d = 1'b1;
    end

    if ((wd_q == TO_W'(1)) && (wd_d == '0)) begin
      reset_out_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      frame_q     <= '0;
      hold_q      <= '0;
      data_q      <= '0;
      strobe_q    <= '0;
      err_q       <= 1'b0;
      reset_out_q <= 1'b0;
      wd_q        <= '0;
    end else begin
      state_q     <= state_d;
      frame_q     <= frame_d;
      hold_q      <= hold_d;
      data_q      <= data_d;
      strobe_q    <= strobe_d;
      err_q       <= err_d;
      reset_out_q <= reset_out_d;
      wd_q        <= wd_d;
    end
  end

  assign strobe    = strobe_q;
  assign data_out  = data_q;
  assign err       = err_q;
  assign reset_out = reset_out_q;

endmodule
